// File: rtl/io_ctrl_if.sv
// io_ctrl_if: bundles the CPU-side instruction controls and the
// peripheral-side output/input handshakes of io_ctrl.
// slave  = the controller itself, master = CPU + peripherals around it.
interface io_ctrl_if #(
    parameter int DW = 8
);
    // CPU side
    logic          wr_req;
    logic          rd_req;
    logic [1:0]    port_sel;
    logic [DW-1:0] wr_data;
    logic          stall;
    logic [DW-1:0] rd_data;
    // Output port handshake (valid/ready)
    logic          out_valid;
    logic [1:0]    out_port;
    logic [DW-1:0] out_data;
    logic          out_ready;
    // Input port handshake (req/ack)
    logic          in_req;
    logic [1:0]    in_port;
    logic          in_ack;
    logic [DW-1:0] in_data;
    // Sticky error flags
    logic [1:0]    err;
    logic          err_clr;

    modport slave (
        input  wr_req, rd_req, port_sel, wr_data,
        input  out_ready, in_ack, in_data, err_clr,
        output stall, rd_data, out_valid, out_port, out_data,
        output in_req, in_port, err
    );

    modport master (
        output wr_req, rd_req, port_sel, wr_data,
        output out_ready, in_ack, in_data, err_clr,
        input  stall, rd_data, out_valid, out_port, out_data,
        input  in_req, in_port, err
    );
endinterface

// File: rtl/io_ctrl.sv
// io_ctrl: CPU I/O instruction controller. An output instruction becomes a
// valid/ready transfer to one of four ports, an input instruction becomes a
// req/ack transfer whose data is captured into rd_data. The CPU is stalled
// until the transfer finishes and commits in the DONE cycle.
// Optional feature: define IO_TIMEOUT_EN to add a handshake watchdog that
// aborts a wait after TIMEOUT cycles (err[0], reads return all-ones).
module io_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    io_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_WAIT = 2'd1,
        IN_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        state_q;
    logic          out_valid_q;
    logic [1:0]    out_port_q;
    logic [DW-1:0] out_data_q;
    logic          in_req_q;
    logic [1:0]    in_port_q;
    logic [DW-1:0] rd_data_q;
    logic [1:0]    err_q;
    logic [1:0]    err_d;
    logic          conflict_set;
    logic          timeout_set;

`ifdef IO_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_hit;

    // The current wait cycle is the TIMEOUT-th one without a handshake.
    assign wd_hit = (wd_q == WD_W'(TIMEOUT - 1));
`else
    // Watchdog absent: TIMEOUT is only referenced so the parameter stays visible.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Sticky error update: new events are OR-ed in after an optional clear,
    // so a set in the same cycle as err_clr survives.
    always_comb begin
        conflict_set = (state_q == IDLE) && bus.wr_req && bus.rd_req;
        timeout_set  = 1'b0;
`ifdef IO_TIMEOUT_EN
        if (wd_hit && (((state_q == OUT_WAIT) && !bus.out_ready) ||
                       ((state_q == IN_WAIT)  && !bus.in_ack))) begin
            timeout_set = 1'b1;
        end
`endif
        err_d = (bus.err_clr ? 2'b00 : err_q) | {conflict_set, timeout_set};
    end

    // Controller FSM with registered handshake outputs and captured data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_port_q  <= 2'b00;
            out_data_q  <= '0;
            in_req_q    <= 1'b0;
            in_port_q   <= 2'b00;
            rd_data_q   <= '0;
            err_q       <= 2'b00;
`ifdef IO_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    // Write wins a simultaneous read; the read is dropped.
                    if (bus.wr_req) begin
                        out_data_q  <= bus.wr_data;
                        out_port_q  <= bus.port_sel;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT_WAIT;
`ifdef IO_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end else if (bus.rd_req) begin
                        in_port_q   <= bus.port_sel;
                        in_req_q    <= 1'b1;
                        state_q     <= IN_WAIT;
`ifdef IO_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end
                end
                OUT_WAIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DONE;
`ifdef IO_TIMEOUT_EN
                    end else if (wd_hit) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        wd_q        <= wd_q + WD_W'(1);
`endif
                    end
                end
                IN_WAIT: begin
                    if (bus.in_ack) begin
                        rd_data_q   <= bus.in_data;
                        in_req_q    <= 1'b0;
                        state_q     <= DONE;
`ifdef IO_TIMEOUT_EN
                    end else if (wd_hit) begin
                        rd_data_q   <= '1;
                        in_req_q    <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        wd_q        <= wd_q + WD_W'(1);
`endif
                    end
                end
                default: begin
                    // DONE: CPU commits this cycle; new requests wait for IDLE.
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the request cycle in IDLE and every wait cycle, never DONE.
    assign bus.stall = !reset &&
                       ((state_q == OUT_WAIT) || (state_q == IN_WAIT) ||
                        ((state_q == IDLE) && (bus.wr_req || bus.rd_req)));

    assign bus.out_valid = out_valid_q;
    assign bus.out_port  = out_port_q;
    assign bus.out_data  = out_data_q;
    assign bus.in_req    = in_req_q;
    assign bus.in_port   = in_port_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed-vector bench for io_ctrl. Inputs change on the
// falling edge, outputs are sampled on the falling edge (or #1 later for
// combinational stall), so every value seen reflects the last rising edge.
module tb_io_ctrl;
    localparam int DW = 8;

    logic clk;
    logic reset;
    int   checks_cnt;
    int   errors_cnt;

    io_ctrl_if #(.DW(DW)) bus ();

    io_ctrl #(.DW(DW), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset = 1'b1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.port_sel = 2'd0;
        bus.wr_data = '0; bus.out_ready = 1'b0; bus.in_ack = 1'b0;
        bus.in_data = '0; bus.err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stall",     bus.stall,     1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_req",    bus.in_req,    1'b0);
        check("rst_rd_data",   bus.rd_data,   8'h00);
        check("rst_err",       bus.err,       2'b00);
        reset = 1'b0;

        // Write 0x5A to port 2, ready on the first OUT_WAIT cycle.
        bus.wr_req = 1'b1; bus.port_sel = 2'd2; bus.wr_data = 8'h5A; bus.out_ready = 1'b1;
        #1 check("w1_stall_idle", bus.stall, 1'b1);
        @(negedge clk);
        check("w1_out_valid", bus.out_valid, 1'b1);
        check("w1_out_port",  bus.out_port,  2'd2);
        check("w1_out_data",  bus.out_data,  8'h5A);
        check("w1_stall_wait", bus.stall,    1'b1);
        check("w1_in_req",    bus.in_req,    1'b0);
        bus.wr_req = 1'b0;
        @(negedge clk);
        check("w1_done_valid", bus.out_valid, 1'b0);
        check("w1_done_stall", bus.stall,     1'b0);
        bus.out_ready = 1'b0;
        $display("TXN write port=2 data=5a");

        // Read port 1, ack arrives on the 4th IN_WAIT cycle with 0xC3.
        @(negedge clk);
        bus.rd_req = 1'b1; bus.port_sel = 2'd1;
        #1 check("r1_stall_idle", bus.stall, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b0;
            check($sformatf("r1_in_req_c%0d", i), bus.in_req, 1'b1);
            check($sformatf("r1_in_port_c%0d", i), bus.in_port, 2'd1);
            if (i == 4) begin
                bus.in_ack = 1'b1; bus.in_data = 8'hC3;
            end
        end
        @(negedge clk);
        check("r1_rd_data",    bus.rd_data, 8'hC3);
        check("r1_done_stall", bus.stall,   1'b0);
        check("r1_done_inreq", bus.in_req,  1'b0);
        bus.in_ack = 1'b0; bus.in_data = 8'h00;
        $display("TXN read port=1 data=c3");

        // Write with ready delayed: data must stay stable, rd_data untouched.
        @(negedge clk);
        bus.wr_req = 1'b1; bus.port_sel = 2'd0; bus.wr_data = 8'h11;
        @(negedge clk);
        bus.wr_req = 1'b0; bus.wr_data = 8'hEE;
        check("w2_valid_c1", bus.out_valid, 1'b1);
        check("w2_data_c1",  bus.out_data,  8'h11);
        @(negedge clk);
        check("w2_valid_c2", bus.out_valid, 1'b1);
        check("w2_data_c2",  bus.out_data,  8'h11);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("w2_done_valid", bus.out_valid, 1'b0);
        check("w2_rd_hold",    bus.rd_data,   8'hC3);
        check("w2_err",        bus.err,       2'b00);
        bus.out_ready = 1'b0;
        $display("TXN write port=0 data=11 delayed ready");

        // Simultaneous write and read: write only, conflict flagged.
        @(negedge clk);
        bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.port_sel = 2'd3;
        bus.wr_data = 8'hA5; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        check("c1_err",      bus.err,      2'b10);
        check("c1_in_req",   bus.in_req,   1'b0);
        check("c1_out_port", bus.out_port, 2'd3);
        check("c1_out_data", bus.out_data, 8'hA5);
        @(negedge clk);
        check("c1_done_inreq", bus.in_req, 1'b0);
        bus.out_ready = 1'b0; bus.err_clr = 1'b1;
        @(negedge clk);
        check("c1_err_clr", bus.err, 2'b00);
        bus.err_clr = 1'b0;
        $display("TXN conflict write port=3 data=a5");

        // Conflict with err_clr in the same cycle: set wins. Then a read
        // request raised during DONE must be ignored.
        bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.err_clr = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.err_clr = 1'b0;
        check("c2_set_wins", bus.err, 2'b10);
        @(negedge clk);
        bus.rd_req = 1'b1;
        #1 check("c2_done_stall", bus.stall, 1'b0);
        @(negedge clk);
        check("c2_done_ignored", bus.in_req, 1'b0);
        bus.rd_req = 1'b0; bus.out_ready = 1'b0; bus.err_clr = 1'b1;
        @(negedge clk);
        check("c2_idle_inreq", bus.in_req, 1'b0);
        check("c2_err_clr",    bus.err,    2'b00);
        bus.err_clr = 1'b0;
        $display("TXN conflict with clear, request in DONE ignored");

        // Read that is never (or only very late) acknowledged.
        bus.rd_req = 1'b1; bus.port_sel = 2'd2;
`ifdef IO_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b0;
            check($sformatf("t1_in_req_c%0d", i), bus.in_req, 1'b1);
        end
        @(negedge clk);
        check("t1_in_req_done", bus.in_req,  1'b0);
        check("t1_rd_data",     bus.rd_data, 8'hFF);
        check("t1_err",         bus.err,     2'b01);
        check("t1_stall",       bus.stall,   1'b0);
        $display("TXN read port=2 timeout");
`else
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b0;
            check($sformatf("t1_in_req_c%0d", i), bus.in_req, 1'b1);
            if (i == 20) begin
                bus.in_ack = 1'b1; bus.in_data = 8'h3C;
            end
        end
        @(negedge clk);
        check("t1_rd_data", bus.rd_data, 8'h3C);
        check("t1_err",     bus.err,     2'b00);
        bus.in_ack = 1'b0;
        $display("TXN read port=2 late ack data=3c");
`endif

        // Asynchronous reset in the middle of OUT_WAIT.
        @(negedge clk);
        bus.wr_req = 1'b1; bus.port_sel = 2'd1; bus.wr_data = 8'h77; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.wr_req = 1'b0;
        check("a1_out_valid_pre", bus.out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("a1_out_valid", bus.out_valid, 1'b0);
        check("a1_stall",     bus.stall,     1'b0);
        check("a1_out_data",  bus.out_data,  8'h00);
        check("a1_out_port",  bus.out_port,  2'd0);
        check("a1_in_port",   bus.in_port,   2'd0);
        check("a1_in_req",    bus.in_req,    1'b0);
        check("a1_rd_data",   bus.rd_data,   8'h00);
        check("a1_err",       bus.err,       2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("a1_idle_valid", bus.out_valid, 1'b0);
        check("a1_idle_stall", bus.stall,     1'b0);
        $display("TXN reset during OUT_WAIT");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
